// File: rtl/fifo_read_port.sv
// fifo_read_port: FWFT read front end that prefetches FIFO memory words into a small output buffer
// Ports:
//   clk_i            clock, all logic on posedge
//   nrst_i           synchronous active-low reset
//   fifo_rd_en_i     consumer pop request
//   fifo_flush_i     discard buffered words and in-flight reads
//   fifo_rd_data_o   head of the output buffer (first-word-fall-through)
//   fifo_empty_o     no word available, or flushing
//   fifo_rd_err_o    registered one-cycle error pulse
//   fifo_rd_count_o  words held in the buffer
//   mem_rd_en_o      memory read strobe
//   mem_rdata_i      memory data, valid MEM_RD_LAT cycles after the strobe
//   mem_empty_i      memory empty flag
//   mem_rd_err_i     memory-side read error
module fifo_read_port #(
   parameter int DATA_WIDTH = 8,
   parameter int MEM_RD_LAT = 1,
   parameter int BUF_DEPTH  = 2
) (
   input  logic                           clk_i,
   input  logic                           nrst_i,
   input  logic                           fifo_rd_en_i,
   input  logic                           fifo_flush_i,
   output logic [DATA_WIDTH-1:0]          fifo_rd_data_o,
   output logic                           fifo_empty_o,
   output logic                           fifo_rd_err_o,
   output logic [$clog2(BUF_DEPTH+1)-1:0] fifo_rd_count_o,
   output logic                           mem_rd_en_o,
   input  logic [DATA_WIDTH-1:0]          mem_rdata_i,
   input  logic                           mem_empty_i,
   input  logic                           mem_rd_err_i
);
   localparam int CW = $clog2(BUF_DEPTH + 1);
   localparam int PW = $clog2(BUF_DEPTH);
   localparam int SW = $clog2(BUF_DEPTH + MEM_RD_LAT + 1);
   typedef enum logic {RUN, FLUSH} state_t;
   state_t                state_q, state_d;
   logic [CW-1:0]         count_q, count_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [MEM_RD_LAT-1:0] pipe_q, pipe_d;
   logic [DATA_WIDTH-1:0] buf_q [BUF_DEPTH];
   logic [DATA_WIDTH-1:0] hold_q;
   logic                  err_q, err_d;
   logic [SW-1:0]         inflight;
   logic                  pop, ret;
   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction
   always_comb begin
      inflight = '0;
      for (int i = 0; i < MEM_RD_LAT; i++) inflight = inflight + SW'(pipe_q[i]);
   end
   // Credits cover both held words and reads still in flight, so the buffer can never overflow.
   assign mem_rd_en_o = nrst_i && state_q == RUN && !fifo_flush_i && !mem_empty_i &&
                        (SW'(count_q) + inflight) < SW'(BUF_DEPTH);
   assign fifo_empty_o    = (count_q == '0) || (state_q == FLUSH);
   assign fifo_rd_count_o = count_q;
   assign fifo_rd_err_o   = err_q;
   // While empty the output keeps showing the last value it presented.
   assign fifo_rd_data_o  = (count_q == '0) ? hold_q : buf_q[rd_ptr_q];
   assign pop = fifo_rd_en_i && !fifo_empty_o;
   assign ret = pipe_q[MEM_RD_LAT-1];
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      err_d     = (fifo_rd_en_i && fifo_empty_o) || mem_rd_err_i;
      pipe_d    = pipe_q << 1;
      pipe_d[0] = mem_rd_en_o;
      if (state_q == RUN && fifo_flush_i) begin
         state_d  = FLUSH;
         count_d  = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else if (state_q == RUN) begin
         wr_ptr_d = ret ? nxt(wr_ptr_q) : wr_ptr_q;
         rd_ptr_d = pop ? nxt(rd_ptr_q) : rd_ptr_q;
         count_d  = count_q + CW'(ret) - CW'(pop);
      end else if (inflight == '0 && !fifo_flush_i) begin
         state_d = RUN;
      end
   end
   always_ff @(posedge clk_i) begin
      if (!nrst_i) begin
         state_q  <= RUN;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         pipe_q   <= '0;
         err_q    <= 1'b0;
         hold_q   <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         pipe_q   <= pipe_d;
         err_q    <= err_d;
         hold_q   <= fifo_rd_data_o;
         // Returns landing in FLUSH, or on the flush edge itself, are dropped.
         if (state_q == RUN && !fifo_flush_i && ret) buf_q[wr_ptr_q] <= mem_rdata_i;
         if (state_q == RUN && !fifo_flush_i && ret && !pop) assert (count_q < CW'(BUF_DEPTH));
      end
   end
endmodule

// File: tb/tb_fifo_read_port.sv
// tb_fifo_read_port: table, directed and randomized checks of fifo_read_port against a queue-based model
module tb_fifo_read_port;
   localparam int LAT = 2;
   localparam int D   = 4;
   logic       clk = 1'b0;
   logic       nrst, rd_en, flush, mem_err, mem_empty, empty, err, iss;
   logic [7:0] mem_rdata, data;
   logic [2:0] count;
   typedef struct {logic [7:0] w; int due; bit live;} rd_t;
   typedef struct packed {logic n, rd, fl, e; logic [2:0] c; logic i, r; logic [7:0] d;} vec_t;
   rd_t        out_q[$];
   logic [7:0] mem_q[$];
   logic [7:0] buf_m[$];
   bit         flushing, err_m;
   logic [7:0] last_m;
   int         cyc, checks, errors;
   logic       s_empty, s_err, s_iss;
   logic [7:0] s_data;
   logic [2:0] s_count;
   vec_t       tbl[21];
   fifo_read_port #(.DATA_WIDTH(8), .MEM_RD_LAT(LAT), .BUF_DEPTH(D)) dut (
      .clk_i(clk), .nrst_i(nrst), .fifo_rd_en_i(rd_en), .fifo_flush_i(flush),
      .fifo_rd_data_o(data), .fifo_empty_o(empty), .fifo_rd_err_o(err), .fifo_rd_count_o(count),
      .mem_rd_en_o(iss), .mem_rdata_i(mem_rdata), .mem_empty_i(mem_empty), .mem_rd_err_i(mem_err)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask
   task automatic cycle(input bit n, input bit rd, input bit fl, input bit me);
      int         infl, ecount;
      bit         eempty, eiss, ret, lret;
      logic [7:0] edata, rw, dummy;
      rd_t        t;
      nrst = n; rd_en = rd; flush = fl; mem_err = me;
      mem_empty = (mem_q.size() == 0);
      ret = out_q.size() > 0 && out_q[0].due == cyc;
      lret = ret && out_q[0].live;
      rw = ret ? out_q[0].w : 8'h00;
      mem_rdata = ret ? rw : 8'($urandom);
      infl = 0;
      foreach (out_q[k]) if (out_q[k].live) infl++;
      ecount = buf_m.size();
      eempty = ecount == 0 || flushing;
      edata  = ecount > 0 ? buf_m[0] : last_m;
      eiss   = n && !flushing && !fl && !mem_empty && (ecount + infl) < D;
      @(negedge clk);
      s_empty = empty; s_count = count; s_iss = iss; s_err = err; s_data = data;
      chk("model_empty", int'(s_empty), int'(eempty));
      chk("model_count", int'(s_count), ecount);
      chk("model_mem_rd_en", int'(s_iss), int'(eiss));
      chk("model_rd_err", int'(s_err), int'(err_m));
      chk("model_rd_data", int'(s_data), int'(edata));
      @(posedge clk);
      if (!n) begin
         buf_m.delete();
         flushing = 0; err_m = 0; last_m = 8'h00;
      end else begin
         err_m  = (rd && eempty) || me;
         last_m = edata;
         if (!flushing) begin
            if (fl) begin
               buf_m.delete();
               flushing = 1;
            end else begin
               if (rd && !eempty) dummy = buf_m.pop_front();
               if (lret) buf_m.push_back(rw);
            end
         end else if (infl == 0 && !fl) flushing = 0;
      end
      if (ret) t = out_q.pop_front();
      if (s_iss && mem_q.size() > 0) begin
         t.w = mem_q.pop_front(); t.due = cyc + LAT; t.live = 1'b1;
         out_q.push_back(t);
      end
      if (!n) foreach (out_q[k]) out_q[k].live = 1'b0;
      cyc++;
      #1;
   endtask
   initial begin
      nrst = 0; rd_en = 0; flush = 0; mem_err = 0; mem_empty = 1; mem_rdata = 8'h00;
      checks = 0; errors = 0; cyc = 0; flushing = 0; err_m = 0; last_m = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      //            n     rd    fl    e     c     i     r     d
      tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 8'h00};
      tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 8'h00};
      tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 8'h00};
      tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 8'h00};
      tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 8'hA0};
      tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 8'hA0};
      tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 8'hA0};
      tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 8'hA0};
      tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 8'hA0};
      tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 8'hA0};
      tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 8'hA1};
      tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 8'hA2};
      tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 8'hA3};
      tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 8'hA4};
      tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 8'hA5};
      tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 8'hA6};
      tbl[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 8'hA7};
      tbl[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 8'hA8};
      tbl[18] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 8'hA9};
      tbl[19] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 8'hAA};
      tbl[20] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 8'hAB};
      for (int i = 0; i < 12; i++) mem_q.push_back(8'hA0 + 8'(i));
      for (int i = 0; i < 21; i++) begin
         cycle(tbl[i].n, tbl[i].rd, tbl[i].fl, 1'b0);
         chk($sformatf("tbl%0d_empty", i), int'(s_empty), int'(tbl[i].e));
         chk($sformatf("tbl%0d_count", i), int'(s_count), int'(tbl[i].c));
         chk($sformatf("tbl%0d_mem_rd_en", i), int'(s_iss), int'(tbl[i].i));
         chk($sformatf("tbl%0d_rd_err", i), int'(s_err), int'(tbl[i].r));
         chk($sformatf("tbl%0d_rd_data", i), int'(s_data), int'(tbl[i].d));
      end
      // last word popped: data holds, memory error pulses one cycle
      cycle(1, 1, 0, 0);
      cycle(1, 0, 0, 1);
      chk("hold_empty", int'(s_empty), 1);
      chk("hold_count", int'(s_count), 0);
      chk("hold_data", int'(s_data), 'hAB);
      cycle(1, 0, 0, 0);
      chk("memerr_pulse", int'(s_err), 1);
      cycle(1, 0, 0, 0);
      chk("memerr_clear", int'(s_err), 0);
      // flush with two reads in flight
      for (int i = 0; i < 6; i++) mem_q.push_back(8'hB0 + 8'(i));
      cycle(1, 0, 0, 0);
      chk("fl_issue0", int'(s_iss), 1);
      cycle(1, 0, 0, 0);
      chk("fl_issue1", int'(s_iss), 1);
      cycle(1, 0, 1, 0);
      chk("fl_edge_issue", int'(s_iss), 0);
      chk("fl_edge_empty", int'(s_empty), 1);
      for (int i = 0; i < 2; i++) begin
         cycle(1, 0, 0, 0);
         chk($sformatf("fl_hold%0d_empty", i), int'(s_empty), 1);
         chk($sformatf("fl_hold%0d_issue", i), int'(s_iss), 0);
      end
      cycle(1, 0, 0, 0);
      chk("fl_resume_issue", int'(s_iss), 1);
      repeat (2) cycle(1, 0, 0, 0);
      cycle(1, 0, 0, 0);
      chk("fl_after_empty", int'(s_empty), 0);
      chk("fl_after_count", int'(s_count), 1);
      chk("fl_after_data", int'(s_data), 'hB2);
      // reset with buffered words and reads in flight
      cycle(0, 0, 0, 0);
      mem_q.delete();
      for (int i = 0; i < 4; i++) mem_q.push_back(8'hC0 + 8'(i));
      repeat (3) cycle(1, 0, 0, 0);
      cycle(1, 0, 0, 0);
      chk("rst_pre_count", int'(s_count), 1);
      cycle(0, 0, 0, 0);
      chk("rst_held_count", int'(s_count), 2);
      chk("rst_held_issue", int'(s_iss), 0);
      cycle(1, 0, 0, 0);
      chk("rst_after_empty", int'(s_empty), 1);
      chk("rst_after_count", int'(s_count), 0);
      chk("rst_after_data", int'(s_data), 0);
      cycle(1, 0, 0, 0);
      chk("rst_late_count", int'(s_count), 0);
      chk("rst_late_empty", int'(s_empty), 1);
      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 2) == 0 && mem_q.size() < 10) mem_q.push_back(8'($urandom));
         if (i % 250 == 0) repeat (8) mem_q.push_back(8'($urandom));
         cycle($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0,
               $urandom_range(0, 24) == 0, $urandom_range(0, 29) == 0);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
